cgra_exec_ctrl: RTL and testbench

Execution sequencer for the torus PE array. It converts the level handshake Computation_Start/Computation_Done into a timed run. The run steps an instruction-memory address over Inst_Len words for Iter_Num iterations, drains the PE pipeline, and then reports completion. It sits between the BRAM interface control logic and the PE array. It drives PE_Array_Busy and the per-cycle instruction fetch.

---
 rtl/cgra_exec_ctrl_if.sv | 29 ++
 rtl/cgra_exec_ctrl.sv | 138 +++++++++++++
 tb/tb_cgra_exec_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_exec_ctrl_if.sv
// Bundles the run handshake, the instruction-fetch bus and the status flags
// exchanged between the BRAM-side control logic and the execution sequencer.
interface cgra_exec_ctrl_if #(
  parameter int IADDR_WIDTH = 8,
  parameter int ITER_WIDTH  = 16
);
  logic                   Computation_Start;
  logic [IADDR_WIDTH:0]   Inst_Len;
  logic [ITER_WIDTH-1:0]  Iter_Num;
  logic                   Stall;
  logic [IADDR_WIDTH-1:0] Inst_Addr;
  logic                   Inst_Rd_En;
  logic                   Inst_Valid;
  logic [ITER_WIDTH-1:0]  Iter_Cnt;
  logic                   PE_Array_Busy;
  logic                   Computation_Done;

  // Software / BRAM-control side: requests runs and observes progress.
  modport master (
    output Computation_Start, Inst_Len, Iter_Num, Stall,
    input  Inst_Addr, Inst_Rd_En, Inst_Valid, Iter_Cnt, PE_Array_Busy, Computation_Done
  );

  // Sequencer side.
  modport slave (
    input  Computation_Start, Inst_Len, Iter_Num, Stall,
    output Inst_Addr, Inst_Rd_En, Inst_Valid, Iter_Cnt, PE_Array_Busy, Computation_Done
  );
endinterface

// File: rtl/cgra_exec_ctrl.sv
// Execution sequencer for the torus PE array. Turns the level Start/Done
// handshake into a timed run: Inst_Len fetches per iteration for Iter_Num
// iterations, a fixed pipeline drain, then a Done flag held until Start drops.
module cgra_exec_ctrl #(
  parameter int IADDR_WIDTH  = 8,
  parameter int ITER_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input logic             Clk,
  input logic             Resetn,
  cgra_exec_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int LEN_WIDTH = IADDR_WIDTH + 1;
  // Largest meaningful length: one full sweep of the instruction memory.
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = {1'b1, {IADDR_WIDTH{1'b0}}};

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  logic [1:0]             state_reg;
  logic [1:0]             state_next;
  logic [IADDR_WIDTH-1:0] addr_reg;
  logic [IADDR_WIDTH-1:0] last_addr_reg;
  logic [IADDR_WIDTH-1:0] launch_last_addr;
  logic [ITER_WIDTH-1:0]  iter_reg;
  logic [ITER_WIDTH-1:0]  last_iter_reg;
  logic [DCW-1:0]         drain_cnt_reg;
  logic                   valid_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   zero_work;
  logic                   launch;
  logic                   rd_en;
  logic                   addr_at_end;
  logic                   last_fetch;

  // Launch qualification and fetch decode for the current cycle.
  always_comb begin
    zero_work   = (bus.Inst_Len == '0) || (bus.Iter_Num == '0);
    launch      = (state_reg == S_IDLE) && bus.Computation_Start && !zero_work;
    // Lengths at or beyond a full memory sweep all end on the top address.
    launch_last_addr = (bus.Inst_Len >= LEN_MAX) ? '1
                     : bus.Inst_Len[IADDR_WIDTH-1:0] - IADDR_WIDTH'(1);
    rd_en       = (state_reg == S_RUN) && !bus.Stall;
    addr_at_end = (addr_reg == last_addr_reg);
    last_fetch  = rd_en && addr_at_end && (iter_reg == last_iter_reg);
  end

  // Sequencer state transitions.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.Computation_Start) begin
          state_next = zero_work ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_fetch) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_reg == '0) begin
          state_next = S_DONE;
        end
      end
      default: begin
        // Done is held until software lowers Start, which also re-arms launch.
        if (!bus.Computation_Start) begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  // State register and registered status flags, derived from the next state.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == S_RUN) || (state_next == S_DRAIN);
      done_reg  <= (state_next == S_DONE);
      valid_reg <= rd_en;
    end
  end

  // Address / iteration stepping; bounds are captured once at launch.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      addr_reg      <= '0;
      iter_reg      <= '0;
      last_addr_reg <= '0;
      last_iter_reg <= '0;
    end else if (launch) begin
      addr_reg      <= '0;
      iter_reg      <= '0;
      last_addr_reg <= launch_last_addr;
      last_iter_reg <= bus.Iter_Num - ITER_WIDTH'(1);
    end else if (rd_en && !last_fetch) begin
      if (addr_at_end) begin
        addr_reg <= '0;
        iter_reg <= iter_reg + ITER_WIDTH'(1);
      end else begin
        addr_reg <= addr_reg + IADDR_WIDTH'(1);
      end
    end
  end

  // Drain down-counter: loaded on the last fetch, free-running through Stall.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      drain_cnt_reg <= '0;
    end else if (last_fetch) begin
      drain_cnt_reg <= DRAIN_LOAD;
    end else if ((state_reg == S_DRAIN) && (drain_cnt_reg != '0)) begin
      drain_cnt_reg <= drain_cnt_reg - DCW'(1);
    end
  end

  assign bus.Inst_Addr        = addr_reg;
  assign bus.Inst_Rd_En       = rd_en;
  assign bus.Inst_Valid       = valid_reg;
  assign bus.Iter_Cnt         = iter_reg;
  assign bus.PE_Array_Busy    = busy_reg;
  assign bus.Computation_Done = done_reg;

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Self-checking bench for cgra_exec_ctrl: a hand-written vector table for the
// basic run, directed multi-cycle sequences, and randomized runs against a
// fetch-count reference model.
module tb_cgra_exec_ctrl;

  localparam int AW    = 8;
  localparam int IW    = 16;
  localparam int DRAIN = 4;

  logic Clk = 1'b0;
  logic Resetn;

  always #5 Clk = ~Clk;

  cgra_exec_ctrl_if #(.IADDR_WIDTH(AW), .ITER_WIDTH(IW)) bus ();

  cgra_exec_ctrl #(
    .IADDR_WIDTH (AW),
    .ITER_WIDTH  (IW),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .Clk   (Clk),
    .Resetn(Resetn),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: progress is tracked as a count of completed fetches.
  int m_active, m_done, m_valid;
  int m_len, m_n, m_f, m_total, m_drain;
  int m_addr, m_iter;

  int obs_addr, obs_iter, obs_rd, obs_valid, obs_busy, obs_done;

  typedef struct {
    int st, stl, len, n;
    int e_addr, e_iter, e_rd, e_valid, e_busy, e_done;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    failures++;
    $display("FAIL %s: cycle bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_valid = 0;
    m_len = 0; m_n = 0; m_f = 0; m_total = 0; m_drain = 0;
    m_addr = 0; m_iter = 0;
  endtask

  function automatic int clamp_len(input int len);
    return (len > (1 << AW)) ? (1 << AW) : len;
  endfunction

  // Advance the model across one rising edge given the inputs it sampled.
  task automatic model_update(input int st, input int stl, input int len, input int n);
    int running, draining, nv, l;
    running  = m_active && (m_f < m_total);
    draining = m_active && (m_f == m_total);
    nv       = running && !stl;
    if (!m_active && !m_done) begin
      if (st != 0) begin
        l = clamp_len(len);
        if (l == 0 || n == 0) begin
          m_done = 1;
        end else begin
          m_active = 1; m_len = l; m_n = n; m_f = 0; m_total = l * n;
          m_drain = DRAIN; m_addr = 0; m_iter = 0;
        end
      end
    end else if (running) begin
      if (!stl) begin
        m_f++;
        if (m_f == m_total) begin
          m_addr = m_len - 1;
          m_iter = m_n - 1;
        end else begin
          m_addr = m_f % m_len;
          m_iter = m_f / m_len;
        end
      end
    end else if (draining) begin
      m_drain--;
      if (m_drain == 0) begin
        m_active = 0;
        m_done   = 1;
      end
    end else if (m_done && !st) begin
      m_done = 0;
    end
    m_valid = nv;
  endtask

  task automatic sample();
    obs_addr  = int'(bus.Inst_Addr);
    obs_iter  = int'(bus.Iter_Cnt);
    obs_rd    = int'(bus.Inst_Rd_En);
    obs_valid = int'(bus.Inst_Valid);
    obs_busy  = int'(bus.PE_Array_Busy);
    obs_done  = int'(bus.Computation_Done);
  endtask

  task automatic drive(input int st, input int stl, input int len, input int n);
    bus.Computation_Start = (st != 0);
    bus.Stall             = (stl != 0);
    bus.Inst_Len          = (AW + 1)'(len);
    bus.Iter_Num          = IW'(n);
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, then advance.
  task automatic tick(input int st, input int stl, input int len, input int n);
    drive(st, stl, len, n);
    @(negedge Clk);
    sample();
    chk("addr",  obs_addr,  m_addr);
    chk("iter",  obs_iter,  m_iter);
    chk("rd_en", obs_rd,    (m_active && (m_f < m_total) && !stl) ? 1 : 0);
    chk("valid", obs_valid, m_valid);
    chk("busy",  obs_busy,  m_active);
    chk("done",  obs_done,  m_done);
    @(posedge Clk);
    model_update(st, stl, len, n);
    #1;
  endtask

  task automatic finish_handshake();
    int guard;
    guard = 0;
    while (m_done != 0 && guard < 4) begin
      tick(0, 0, 0, 0);
      guard++;
    end
    if (m_done != 0) bound_expired("handshake_release");
  endtask

  task automatic check_all_zero(input string tag);
    sample();
    chk({tag, "_addr"},  obs_addr,  0);
    chk({tag, "_iter"},  obs_iter,  0);
    chk({tag, "_rd_en"}, obs_rd,    0);
    chk({tag, "_valid"}, obs_valid, 0);
    chk({tag, "_busy"},  obs_busy,  0);
    chk({tag, "_done"},  obs_done,  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, busy_n, nv, first_v, last_v, stalls, addr2, cnt, max_addr, wraps, prev_addr;
    int stl, st, len, n;

    // ---------------- reset ----------------
    Resetn = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_all_zero("reset");
    Resetn = 1'b1;
    @(posedge Clk);
    #1;
    $display("reset: outputs checked");

    // ---------------- basic run table: Len=4, N=2 ----------------
    // Len/N change after launch to show they are only sampled once.
    vecs[0]  = '{1, 0, 4, 2,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 9, 5,  0, 0, 1, 0, 1, 0};
    vecs[2]  = '{1, 0, 9, 5,  1, 0, 1, 1, 1, 0};
    vecs[3]  = '{1, 0, 9, 5,  2, 0, 1, 1, 1, 0};
    vecs[4]  = '{1, 0, 9, 5,  3, 0, 1, 1, 1, 0};
    vecs[5]  = '{1, 0, 9, 5,  0, 1, 1, 1, 1, 0};
    vecs[6]  = '{1, 0, 9, 5,  1, 1, 1, 1, 1, 0};
    vecs[7]  = '{1, 0, 9, 5,  2, 1, 1, 1, 1, 0};
    vecs[8]  = '{1, 0, 9, 5,  3, 1, 1, 1, 1, 0};
    vecs[9]  = '{1, 1, 9, 5,  3, 1, 0, 1, 1, 0};
    vecs[10] = '{1, 1, 9, 5,  3, 1, 0, 0, 1, 0};
    vecs[11] = '{1, 0, 9, 5,  3, 1, 0, 0, 1, 0};
    vecs[12] = '{1, 0, 9, 5,  3, 1, 0, 0, 1, 0};
    vecs[13] = '{1, 0, 9, 5,  3, 1, 0, 0, 0, 1};
    vecs[14] = '{0, 0, 9, 5,  3, 1, 0, 0, 0, 1};
    vecs[15] = '{0, 0, 9, 5,  3, 1, 0, 0, 0, 0};
    for (int r = 0; r < 16; r++) begin
      drive(vecs[r].st, vecs[r].stl, vecs[r].len, vecs[r].n);
      @(negedge Clk);
      sample();
      chk($sformatf("vec%0d_addr", r),  obs_addr,  vecs[r].e_addr);
      chk($sformatf("vec%0d_iter", r),  obs_iter,  vecs[r].e_iter);
      chk($sformatf("vec%0d_rd_en", r), obs_rd,    vecs[r].e_rd);
      chk($sformatf("vec%0d_valid", r), obs_valid, vecs[r].e_valid);
      chk($sformatf("vec%0d_busy", r),  obs_busy,  vecs[r].e_busy);
      chk($sformatf("vec%0d_done", r),  obs_done,  vecs[r].e_done);
      @(posedge Clk);
      model_update(vecs[r].st, vecs[r].stl, vecs[r].len, vecs[r].n);
      #1;
    end
    $display("table: basic run Len=4 N=2 applied (16 vectors)");

    // ---------------- zero work ----------------
    tick(1, 0, 5, 0);
    tick(1, 0, 5, 0);
    chk("zero_iter_done", obs_done, 1);
    chk("zero_iter_busy", obs_busy, 0);
    tick(0, 0, 5, 0);
    tick(0, 0, 5, 0);
    chk("zero_iter_release", obs_done, 0);
    tick(1, 0, 0, 3);
    tick(1, 0, 0, 3);
    chk("zero_len_done", obs_done, 1);
    chk("zero_len_busy", obs_busy, 0);
    finish_handshake();
    $display("zero work: Iter_Num=0 and Inst_Len=0 launches");

    // ---------------- stall while Inst_Addr=2 ----------------
    busy_n = 0; nv = 0; first_v = -1; last_v = -1; stalls = 0; addr2 = 0;
    tick(1, 0, 4, 1);
    for (cyc = 1; cyc < 100 && m_done == 0; cyc++) begin
      stl = (m_active && m_f < m_total && m_addr == 2 && stalls < 3) ? 1 : 0;
      stalls += stl;
      tick(1, stl, 4, 1);
      if (obs_busy != 0) busy_n++;
      if (obs_busy != 0 && obs_addr == 2) addr2++;
      if (obs_valid != 0) begin
        nv++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
    end
    if (m_done == 0) bound_expired("stall_run");
    chk("stall_busy_len", busy_n, 11);
    chk("stall_valid_gap", last_v - first_v + 1 - nv, 3);
    chk("stall_addr2_cycles", addr2, 4);
    finish_handshake();
    $display("stall: Len=4 N=1 with 3 stall cycles at addr 2, busy=%0d", busy_n);

    // ---------------- handshake: Start held after Done ----------------
    tick(1, 0, 2, 1);
    for (cyc = 0; cyc < 50 && m_done == 0; cyc++) tick(1, 0, 2, 1);
    if (m_done == 0) bound_expired("hold_run");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 7, 7);
      if (obs_done != 0 && obs_busy == 0) cnt++;
    end
    chk("hold_done_cycles", cnt, 20);
    tick(0, 0, 7, 7);
    chk("drop_done_same_cycle", obs_done, 1);
    tick(0, 0, 7, 7);
    chk("drop_done_next", obs_done, 0);
    busy_n = 0; max_addr = 0;
    tick(1, 0, 5, 1);
    for (cyc = 0; cyc < 50 && m_done == 0; cyc++) begin
      tick(1, 0, 9, 3);
      if (obs_busy != 0) busy_n++;
      if (obs_addr > max_addr) max_addr = obs_addr;
    end
    if (m_done == 0) bound_expired("relaunch_run");
    chk("relaunch_busy_len", busy_n, 9);
    chk("relaunch_max_addr", max_addr, 4);
    finish_handshake();
    $display("handshake: hold, release, relaunch with Len=5");

    // ---------------- Start drops mid-run ----------------
    busy_n = 0; cnt = 0;
    tick(1, 0, 8, 1);
    for (cyc = 1; cyc < 60 && (m_active != 0 || cyc < 3); cyc++) begin
      tick((cyc < 3) ? 1 : 0, 0, 8, 1);
      if (obs_busy != 0) busy_n++;
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 8, 1);
      if (obs_done != 0) cnt++;
    end
    chk("middrop_busy_len", busy_n, 12);
    chk("middrop_done_cycles", cnt, 1);
    $display("start drop: Len=8 N=1, done pulses=%0d", cnt);

    // ---------------- reset mid-run ----------------
    tick(1, 0, 8, 2);
    for (cyc = 0; cyc < 40 && !(m_active != 0 && m_addr == 5); cyc++) tick(1, 0, 8, 2);
    if (!(m_active != 0 && m_addr == 5)) bound_expired("reset_reach_addr5");
    chk("pre_reset_addr", int'(bus.Inst_Addr), 5);
    Resetn = 1'b0;
    #2;
    check_all_zero("midrun_reset");
    model_reset();
    bus.Computation_Start = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Resetn = 1'b1;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 8, 2);
      chk("post_reset_busy", obs_busy, 0);
      chk("post_reset_done", obs_done, 0);
    end
    $display("reset: aborted run at addr 5, idle after release");

    // ---------------- full-depth and clamped lengths ----------------
    for (int k = 0; k < 2; k++) begin
      len = (k == 0) ? 256 : 400;
      n   = (k == 0) ? 2 : 1;
      wraps = 0; max_addr = 0; prev_addr = 0; busy_n = 0;
      tick(1, 0, len, n);
      for (cyc = 0; cyc < 1000 && m_done == 0; cyc++) begin
        tick(1, 0, len, n);
        if (obs_busy != 0) busy_n++;
        if (obs_busy != 0 && prev_addr == 255 && obs_addr == 0) wraps++;
        if (obs_addr > max_addr) max_addr = obs_addr;
        prev_addr = obs_addr;
      end
      if (m_done == 0) bound_expired("long_run");
      chk($sformatf("len%0d_max_addr", len), max_addr, 255);
      chk($sformatf("len%0d_wraps", len), wraps, n - 1);
      chk($sformatf("len%0d_busy_len", len), busy_n, 256 * n + DRAIN);
      finish_handshake();
      $display("long run: Inst_Len=%0d N=%0d busy=%0d", len, n, busy_n);
    end

    // ---------------- randomized runs vs model ----------------
    for (int run = 0; run < 25; run++) begin
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 12));
      n   = (len > 20) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 4));
      repeat ($urandom_range(0, 3)) tick(0, $urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 9));
      tick(1, 0, len, n);
      for (cyc = 0; cyc < 5000 && m_active != 0; cyc++) begin
        st  = ($urandom_range(0, 3) != 0) ? 1 : 0;
        stl = ($urandom_range(0, 3) == 0) ? 1 : 0;
        tick(st, stl, $urandom_range(0, 511), $urandom_range(0, 9));
      end
      if (m_active != 0) bound_expired("random_run");
      for (cyc = 0; cyc < 60 && m_done != 0; cyc++) begin
        tick($urandom_range(0, 1), 0, $urandom_range(0, 511), $urandom_range(0, 9));
      end
      if (m_done != 0) bound_expired("random_release");
      $display("random run %0d: len=%0d n=%0d", run, len, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
